// File: rtl/branch_predictor.sv
// branch_predictor
//   Fetch-stage direct-mapped BTB with 2-bit saturating counters. It predicts
//   the next PC for pc_f every cycle and carries that prediction into execute.
//   In execute it compares the prediction with the resolved outcome, requests
//   a redirect on a mispredict, and trains the table.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   pc_f              fetch PC (word aligned)
//   stall, flush      hold / kill the fetch->execute prediction register
//   pred_taken        combinational taken prediction for pc_f
//   pred_target       combinational predicted next PC for pc_f
//   upd_valid         valid instruction in execute
//   upd_pc            execute-stage PC
//   upd_br_type       000..101 conditional, 110 not a branch, 111 jump
//   upd_taken         resolved branch outcome
//   upd_target        resolved branch/jump target
//   mispredict        combinational redirect request
//   redirect_pc       correct next PC; meaningful only when mispredict=1
//
// Handshake: there is no back-pressure. upd_valid qualifies the upd_* bundle
// for one cycle; mispredict is a single-cycle pulse that the pipeline answers
// with flush in the same cycle.
module branch_predictor #(
  parameter int ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_f,
  input  logic        stall,
  input  logic        flush,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic [2:0]  upd_br_type,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  output logic        mispredict,
  output logic [31:0] redirect_pc
);

  localparam int IDX   = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX;

  logic             valid_q [ENTRIES];
  logic [1:0]       ctr_q   [ENTRIES];
  logic [TAG_W-1:0] tag_q   [ENTRIES];
  logic [31:0]      tgt_q   [ENTRIES];

  logic        pred_taken_e;
  logic [31:0] pred_target_e;

  // Byte-offset bits never reach the table.
  logic unused_lsbs;
  assign unused_lsbs = ^{pc_f[1:0], upd_pc[1:0]};

  // ---------------- fetch lookup ----------------
  logic [IDX-1:0]   f_idx;
  logic [TAG_W-1:0] f_tag;
  logic             f_hit;

  assign f_idx       = pc_f[IDX+1:2];
  assign f_tag       = pc_f[31:IDX+2];
  assign f_hit       = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign pred_taken  = f_hit && ctr_q[f_idx][1];
  assign pred_target = pred_taken ? tgt_q[f_idx] : pc_f + 32'd4;

  // ---------------- fetch -> execute register ----------------
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      pred_taken_e  <= 1'b0;
      pred_target_e <= 32'd0;
    end else if (!stall) begin
      pred_taken_e  <= pred_taken;
      pred_target_e <= pred_target;
    end
  end

  // ---------------- execute compare ----------------
  logic [IDX-1:0]   u_idx;
  logic [TAG_W-1:0] u_tag;
  logic             u_hit;
  logic             is_jump;
  logic             is_nb;
  logic             is_cond;
  logic             taken_eff;

  assign u_idx     = upd_pc[IDX+1:2];
  assign u_tag     = upd_pc[31:IDX+2];
  assign u_hit     = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
  assign is_jump   = (upd_br_type == 3'b111);
  assign is_nb     = (upd_br_type == 3'b110);
  assign is_cond   = !is_jump && !is_nb;
  assign taken_eff = !is_nb && upd_taken;

  // A taken/taken pair still mispredicts if the targets disagree.
  assign mispredict  = upd_valid &&
                       ((taken_eff != pred_taken_e) ||
                        (taken_eff && pred_taken_e && (upd_target != pred_target_e)));
  assign redirect_pc = taken_eff ? upd_target : upd_pc + 32'd4;

  // ---------------- training ----------------
  // Tag/target are written only on allocation, jump, or taken hit; on a
  // taken hit the tag already matches, so rewriting it is harmless.
  logic write_tt;
  assign write_tt = upd_valid && (is_jump || (is_cond && upd_taken));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= 2'b01;
      end
    end else if (upd_valid) begin
      if (is_jump) begin
        valid_q[u_idx] <= 1'b1;
        ctr_q[u_idx]   <= 2'b11;
      end else if (is_nb) begin
        // Non-branch that hit means an alias; drop the entry.
        if (u_hit) valid_q[u_idx] <= 1'b0;
      end else if (u_hit) begin
        if (upd_taken) begin
          if (ctr_q[u_idx] != 2'b11) ctr_q[u_idx] <= ctr_q[u_idx] + 2'd1;
        end else begin
          if (ctr_q[u_idx] != 2'b00) ctr_q[u_idx] <= ctr_q[u_idx] - 2'd1;
        end
      end else if (upd_taken) begin
        valid_q[u_idx] <= 1'b1;
        ctr_q[u_idx]   <= 2'b10;
      end
    end
  end

  // Tags and targets carry no reset; an update in a reset cycle is dropped.
  always_ff @(posedge clk) begin
    if (!rst && write_tt) begin
      tag_q[u_idx] <= u_tag;
      tgt_q[u_idx] <= upd_target;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_f = 32'h100;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = 32'h0;
  logic [2:0]  upd_br_type = 3'b110;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = 32'h0;
  logic        mispredict;
  logic [31:0] redirect_pc;

  always #5 clk = ~clk;

  branch_predictor #(.ENTRIES(16)) dut (
    .clk(clk), .rst(rst), .pc_f(pc_f), .stall(stall), .flush(flush),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_br_type(upd_br_type),
    .upd_taken(upd_taken), .upd_target(upd_target),
    .mispredict(mispredict), .redirect_pc(redirect_pc)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // One record per slot, keyed by full upper PC; counter as an integer 0..3.
  bit          m_valid [16];
  int unsigned m_tag   [16];
  logic [31:0] m_tgt   [16];
  int          m_ctr   [16];
  bit          m_pte;
  logic [31:0] m_ptge;

  function automatic int slot(input logic [31:0] pc);
    return int'((pc / 4) % 16);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[slot(pc)] && (m_tag[slot(pc)] == pc / 64);
  endfunction

  // Scoreboard: compares every cycle at the falling edge, then advances the
  // model to the state the next rising edge will produce.
  always @(negedge clk) begin
    bit          e_pt, teff, e_mis, hit;
    logic [31:0] e_ptg;
    int          s;
    e_pt  = m_hit(pc_f) && (m_ctr[slot(pc_f)] >= 2);
    e_ptg = e_pt ? m_tgt[slot(pc_f)] : pc_f + 32'd4;
    teff  = (upd_br_type != 3'b110) && upd_taken;
    e_mis = upd_valid && ((teff != m_pte) || (teff && m_pte && upd_target != m_ptge));
    if (chk_en) begin
      chk("pred_taken",  {31'd0, pred_taken}, {31'd0, e_pt});
      chk("pred_target", pred_target, e_ptg);
      chk("mispredict",  {31'd0, mispredict}, {31'd0, e_mis});
      if (e_mis) chk("redirect_pc", redirect_pc, teff ? upd_target : upd_pc + 32'd4);
    end
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        m_valid[i] = 1'b0;
        m_ctr[i]   = 1;
      end
      m_pte  = 1'b0;
      m_ptge = 32'd0;
    end else begin
      if (upd_valid) begin
        s   = slot(upd_pc);
        hit = m_hit(upd_pc);
        if (upd_br_type == 3'b111) begin
          m_valid[s] = 1'b1; m_tag[s] = upd_pc / 64; m_tgt[s] = upd_target; m_ctr[s] = 3;
        end else if (upd_br_type == 3'b110) begin
          if (hit) m_valid[s] = 1'b0;
        end else if (hit) begin
          if (upd_taken) begin
            m_ctr[s] = (m_ctr[s] + 1 > 3) ? 3 : m_ctr[s] + 1;
            m_tgt[s] = upd_target;
          end else begin
            m_ctr[s] = (m_ctr[s] - 1 < 0) ? 0 : m_ctr[s] - 1;
          end
        end else if (upd_taken) begin
          m_valid[s] = 1'b1; m_tag[s] = upd_pc / 64; m_tgt[s] = upd_target; m_ctr[s] = 2;
        end
      end
      if (flush) begin
        m_pte = 1'b0; m_ptge = 32'd0;
      end else if (!stall) begin
        m_pte = e_pt; m_ptge = e_ptg;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Inputs change just after the rising edge and stay stable to the next one;
  // each call returns at the falling edge so literal checks can follow.
  task automatic cyc(input bit r, input logic [31:0] pc, input bit st, input bit fl,
                     input bit uv, input logic [31:0] upc, input logic [2:0] ty,
                     input bit tk, input logic [31:0] tgt);
    @(posedge clk);
    #1;
    rst = r; pc_f = pc; stall = st; flush = fl;
    upd_valid = uv; upd_pc = upc; upd_br_type = ty; upd_taken = tk; upd_target = tgt;
    @(negedge clk);
  endtask

  task automatic idle(input logic [31:0] pc);
    cyc(0, pc, 0, 0, 0, 32'h0, 3'b110, 0, 32'h0);
  endtask

  task automatic upd(input logic [31:0] pc, input logic [31:0] upc, input logic [2:0] ty,
                     input bit tk, input logic [31:0] tgt);
    cyc(0, pc, 0, 0, 1, upc, ty, tk, tgt);
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    @(negedge clk);
    cyc(1, 32'h100, 0, 0, 0, 32'h0, 3'b110, 0, 32'h0);
    chk_en = 1'b1;

    // Cold lookup after reset
    idle(32'h100);
    chk("cold_pt", {31'd0, pred_taken}, 32'd0);
    chk("cold_ptg", pred_target, 32'h104);

    // Allocation; same-cycle lookup still sees the old (empty) entry
    upd(32'h100, 32'h100, 3'b000, 1, 32'h80);
    chk("alloc_mis", {31'd0, mispredict}, 32'd1);
    chk("alloc_redir", redirect_pc, 32'h80);
    chk("rbw_pt", {31'd0, pred_taken}, 32'd0);
    idle(32'h100);
    chk("alloc_pt", {31'd0, pred_taken}, 32'd1);
    chk("alloc_ptg", pred_target, 32'h80);

    // ctr 10 -> 01 with pred_taken_e=1
    upd(32'h100, 32'h100, 3'b000, 0, 32'h80);
    chk("nt_mis", {31'd0, mispredict}, 32'd1);
    chk("nt_redir", redirect_pc, 32'h104);
    idle(32'h100);
    chk("ctr01_pt", {31'd0, pred_taken}, 32'd0);
    upd(32'h100, 32'h100, 3'b000, 0, 32'h80);           // -> 00
    upd(32'h100, 32'h100, 3'b000, 1, 32'h80);           // -> 01
    upd(32'h100, 32'h100, 3'b000, 1, 32'h80);           // -> 10
    upd(32'h100, 32'h100, 3'b000, 1, 32'h80);           // -> 11
    idle(32'h100);
    chk("ctr11_pt", {31'd0, pred_taken}, 32'd1);
    upd(32'h100, 32'h100, 3'b000, 1, 32'h80);           // saturates at 11
    upd(32'h100, 32'h100, 3'b000, 0, 32'h80);           // -> 10
    idle(32'h100);
    chk("sat_pt", {31'd0, pred_taken}, 32'd1);

    // Aliasing
    idle(32'h140);
    chk("alias_pt", {31'd0, pred_taken}, 32'd0);
    idle(32'h100);
    upd(32'h100, 32'h100, 3'b110, 0, 32'h0);
    chk("nb_mis", {31'd0, mispredict}, 32'd1);
    chk("nb_redir", redirect_pc, 32'h104);
    idle(32'h100);
    chk("inval_pt", {31'd0, pred_taken}, 32'd0);

    // Jump
    upd(32'h200, 32'h200, 3'b111, 1, 32'h300);
    idle(32'h200);
    chk("jmp_pt", {31'd0, pred_taken}, 32'd1);
    chk("jmp_ptg", pred_target, 32'h300);
    upd(32'h200, 32'h200, 3'b111, 1, 32'h300);
    chk("jmp_mis", {31'd0, mispredict}, 32'd0);

    // flush + stall together zero the execute prediction
    cyc(0, 32'h200, 1, 1, 0, 32'h0, 3'b110, 0, 32'h0);
    upd(32'h200, 32'h200, 3'b111, 1, 32'h300);
    chk("flush_mis", {31'd0, mispredict}, 32'd1);

    // Reset pulse after training
    cyc(1, 32'h200, 0, 0, 0, 32'h0, 3'b110, 0, 32'h0);
    idle(32'h200);
    chk("rst_pt", {31'd0, pred_taken}, 32'd0);

    // Random traffic over a small PC space so entries alias
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] p, up, t;
      p  = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
      up = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
      t  = $urandom_range(0, 7) << 4;
      cyc($urandom_range(0, 99) == 0, p, $urandom_range(0, 4) == 0,
          $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 7, up,
          3'($urandom_range(0, 7)), $urandom_range(0, 1) == 1, t);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Fetch-stage branch predictor and redirect unit for the 3-stage pipeline. It holds a direct-mapped branch target buffer (BTB) with 2-bit saturating counters and predicts next-PC for the fetch PC every cycle. It carries each prediction into execute and compares it there against the resolved outcome from the branch comparator (`br_taken`). On a misprediction it raises a redirect request and trains the table.

## Interface
Parameters:
- `ENTRIES`, 16, BTB entries; power of two, ≥2; `IDX = log2(ENTRIES)`.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `pc_f`  in  32  fetch-stage PC (word aligned).
- `stall`  in  1  hold fetch→execute prediction register.
- `flush`  in  1  kill the instruction entering execute; its prediction is zeroed.
- `pred_taken`  out  1  combinational prediction for `pc_f`.
- `pred_target`  out  32  predicted next PC for `pc_f`.
- `upd_valid`  in  1  valid instruction in execute this cycle.
- `upd_pc`  in  32  PC of execute-stage instruction.
- `upd_br_type`  in  3  branch type: 000 beq, 001 bne, 010 blt, 011 bge, 100 bltu, 101 bgeu, 111 jump, 110 not a branch.
- `upd_taken`  in  1  resolved outcome (comparator `br_taken`).
- `upd_target`  in  32  resolved branch/jump target.
- `mispredict`  out  1  combinational redirect request.
- `redirect_pc`  out  32  correct next PC when `mispredict`=1.

## Operation
- Index = `pc[IDX+1:2]`; tag = `pc[31:IDX+2]`. Entry = {valid, tag, target[31:0], ctr[1:0]}.
- Lookup (combinational): hit = valid & tag match. `pred_taken` = hit & ctr[1]. `pred_target` = pred_taken ? entry.target : `pc_f`+4 (mod 2^32).
- Execute register {`pred_taken_e`, `pred_target_e`}: on `rst` or `flush`, loaded with {0, 0}. Else, on `!stall`, loaded with {`pred_taken`, `pred_target`}. Else held. `flush` has priority over `stall`.
- Effective outcome: `taken_eff` = `upd_taken` if `upd_br_type` ≠ 110, else 0.
- `mispredict` = `upd_valid` & ((`taken_eff` ≠ `pred_taken_e`) | (`taken_eff` & `pred_taken_e` & `upd_target` ≠ `pred_target_e`)).
- `redirect_pc` = `taken_eff` ? `upd_target` : `upd_pc`+4. It is driven to this value every cycle, and is meaningful only when `mispredict`=1.
- Training happens only when `upd_valid`=1, at the index/tag of `upd_pc`:
  - Type 111, any hit state: write valid=1, tag, target=`upd_target`, ctr=11.
  - Conditional type, hit: taken → ctr saturating +1 and target=`upd_target`; not taken → ctr saturating −1 (target kept).
  - Conditional type, miss, taken: allocate (overwriting any alias); ctr=10, target=`upd_target`.
  - Conditional type, miss, not taken: no write.
  - Type 110, hit: clear valid (aliased entry). Type 110, miss: no write.
- Reset: all valid bits 0 and all ctr = 01. Tags and targets need no reset.

## Timing
- Lookup is zero-latency: `pred_*` depend on `pc_f` in the same cycle.
- A table write on edge N is visible to a lookup in cycle N+1. A same-cycle lookup of the index being written returns the pre-write contents (read-before-write).
- `pred_*_e` lags fetch by exactly one unstalled cycle.
- `mispredict` and `redirect_pc` are combinational from `upd_*` and `pred_*_e`, with no added latency. The pipeline responds by asserting `flush` the same cycle.
- Output reset values: `pred_taken`=0, `pred_target`=`pc_f`+4, `pred_*_e`=0, `mispredict` = `upd_valid` & `taken_eff`.
- Reset asserted mid-operation clears the table and the execute register on that edge. A pending update in that cycle is discarded.
- Simultaneous `stall` and a training update: the table still trains; only the execute register holds.

## Test plan
All scenarios use `ENTRIES`=16.
- Post-reset cold lookup: `pc_f`=0x100 → `pred_taken`=0, `pred_target`=0x104.
- Allocation:
  - Stimulus: `upd_valid`=1, `upd_pc`=0x100, type 000, `upd_taken`=1, `upd_target`=0x80, `pred_taken_e`=0.
  - Response: `mispredict`=1, `redirect_pc`=0x80.
  - Next cycle `pc_f`=0x100 → `pred_taken`=1, `pred_target`=0x80.
- Counter training:
  - From ctr=10, one not-taken update at 0x100 → ctr=01; lookup of 0x100 gives `pred_taken`=0.
  - If that update had `pred_taken_e`=1: `mispredict`=1, `redirect_pc`=0x104.
  - A second not-taken update → ctr=00. Three taken updates → ctr=11, with no wrap past 11.
- Aliasing:
  - Entry for 0x100 valid; `pc_f`=0x140 (same index 0, different tag) → `pred_taken`=0.
  - Type-110 update at 0x100 with `pred_taken_e`=1 → `mispredict`=1, `redirect_pc`=0x104; the entry is invalidated.
- Jump: type 111 update at 0x200 with target 0x300 → following lookup of 0x200 gives `pred_taken`=1, `pred_target`=0x300. A later update with `pred_*_e`={1, 0x300} and `upd_target`=0x300 → `mispredict`=0.
- Hazards:
  - Same-cycle update and lookup of 0x100 returns the old prediction.
  - `flush`+`stall` together → `pred_taken_e`=0.
  - `rst` pulse after training → lookup of 0x100 gives `pred_taken`=0.
